// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader
// Description : Writer side of the per-neuron weight memories. Parses a
//               framed word stream (header, count, weights) arriving over a
//               valid/ready handshake. Each accepted weight becomes one
//               registered write (layer, neuron, address, data). The module
//               pulses done on a clean load and err on a framing error, and
//               records the error cause in err_code.
//               Optional macro WLOAD_CHECKSUM_EN adds a trailing checksum
//               word (sum of weights mod 2^DATA_WIDTH) after the weights.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_loader #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 10,
    parameter int NUM_WEIGHT    = 784,
    parameter int LAYER_BITS    = 4,
    parameter int NEURON_BITS   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_last,
    output logic                     wr_en,
    output logic [LAYER_BITS-1:0]    wr_layer,
    output logic [NEURON_BITS-1:0]   wr_neuron,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [2:0]               err_code
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_count = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
`ifdef WLOAD_CHECKSUM_EN
    localparam logic [2:0] c_st_check = 3'd4;
    localparam logic [2:0] c_err_cksum = 3'd5;
`endif

    localparam logic [2:0] c_err_trunc = 3'd1;
    localparam logic [2:0] c_err_count = 3'd2;
    localparam logic [2:0] c_err_short = 3'd3;
    localparam logic [2:0] c_err_long  = 3'd4;

    localparam logic [DATA_WIDTH-1:0]    c_max_cnt  = DATA_WIDTH'(NUM_WEIGHT);
    localparam logic [DATA_WIDTH-1:0]    c_cnt_one  = DATA_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_one = ADDRESS_WIDTH'(1);

    logic [2:0]               r_state;
    logic                     r_s_ready;
    logic [LAYER_BITS-1:0]    r_layer;
    logic [NEURON_BITS-1:0]   r_neuron;
    logic [DATA_WIDTH-1:0]    r_cnt;
    logic [ADDRESS_WIDTH-1:0] r_index;
    logic                     r_wr_en;
    logic [LAYER_BITS-1:0]    r_wr_layer;
    logic [NEURON_BITS-1:0]   r_wr_neuron;
    logic [ADDRESS_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0]    r_wr_data;
    logic                     r_done;
    logic                     r_err;
    logic [2:0]               r_err_code;
`ifdef WLOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    r_sum;
`endif

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_index_ext;
    logic                  w_final;
    logic                  w_cnt_bad;

    // The RAM never stalls, so ready is simply "out of reset".
    assign w_accept    = s_valid && r_s_ready;
    assign w_index_ext = DATA_WIDTH'(r_index);
    // Current weight is the last one the count announced.
    assign w_final     = (w_index_ext == (r_cnt - c_cnt_one));
    assign w_cnt_bad   = (s_data == '0) || (s_data > c_max_cnt);

    // Frame parser: state, latched header/count/index and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_s_ready   <= 1'b0;
            r_layer     <= '0;
            r_neuron    <= '0;
            r_cnt       <= '0;
            r_index     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_layer  <= '0;
            r_wr_neuron <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
`ifdef WLOAD_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_s_ready <= 1'b1;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    c_st_idle: begin
                        r_neuron <= s_data[NEURON_BITS-1:0];
                        r_layer  <= s_data[LAYER_BITS+NEURON_BITS-1:NEURON_BITS];
                        if (s_last) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_trunc;
                        end else begin
                            r_state <= c_st_count;
                        end
                    end
                    c_st_count: begin
                        r_cnt   <= s_data;
                        r_index <= '0;
`ifdef WLOAD_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                        if (w_cnt_bad) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_count;
                            r_state    <= s_last ? c_st_idle : c_st_drain;
                        end else if (s_last) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_trunc;
                            r_state    <= c_st_idle;
                        end else begin
                            r_state <= c_st_data;
                        end
                    end
                    c_st_data: begin
                        r_wr_en     <= 1'b1;
                        r_wr_layer  <= r_layer;
                        r_wr_neuron <= r_neuron;
                        r_wr_addr   <= r_index;
                        r_wr_data   <= s_data;
                        r_index     <= r_index + c_addr_one;
`ifdef WLOAD_CHECKSUM_EN
                        r_sum       <= r_sum + s_data;
                        // The checksum word must follow the final weight.
                        if (w_final && !s_last) begin
                            r_state <= c_st_check;
                        end else if (s_last) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_short;
                            r_state    <= c_st_idle;
                        end
`else
                        if (w_final) begin
                            if (s_last) begin
                                r_done  <= 1'b1;
                                r_state <= c_st_idle;
                            end else begin
                                r_err      <= 1'b1;
                                r_err_code <= c_err_long;
                                r_state    <= c_st_drain;
                            end
                        end else if (s_last) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_short;
                            r_state    <= c_st_idle;
                        end
`endif
                    end
`ifdef WLOAD_CHECKSUM_EN
                    c_st_check: begin
                        if (!s_last) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_long;
                            r_state    <= c_st_drain;
                        end else if (s_data == r_sum) begin
                            r_done  <= 1'b1;
                            r_state <= c_st_idle;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_cksum;
                            r_state    <= c_st_idle;
                        end
                    end
`endif
                    c_st_drain: begin
                        if (s_last) begin
                            r_state <= c_st_idle;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign wr_en     = r_wr_en;
    assign wr_layer  = r_wr_layer;
    assign wr_neuron = r_wr_neuron;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state != c_st_idle);
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire
